// File: rtl/mul_pkg.sv
// Shared types and the clamp-add helper for the multiplier accumulation stage.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    localparam int unsigned PROD_W = 8;
    localparam int unsigned SAT_W  = 16;

    // Returns {saturated, sum}; the sum is clamped to 2^width-1 with width <= SAT_W.
    function automatic logic [SAT_W:0] sat_add(
        input logic [SAT_W-1:0]  a,
        input logic [PROD_W-1:0] b,
        input int unsigned       width
    );
        logic [SAT_W:0] total;
        logic [SAT_W:0] lim;
        total = {1'b0, a} + {{(SAT_W + 1 - PROD_W){1'b0}}, b};
        lim   = ({{SAT_W{1'b0}}, 1'b1} << width) - {{SAT_W{1'b0}}, 1'b1};
        if (total > lim) begin
            return {1'b1, lim[SAT_W-1:0]};
        end
        return {1'b0, total[SAT_W-1:0]};
    endfunction

endpackage

// File: rtl/mul_accum_stage.sv
// Sums the multiplier product stream into a saturating accumulator per frame
// and presents each frame sum on a valid/ready port.
module mul_accum_stage
    import mul_pkg::*;
#(
    parameter int unsigned ACC_W     = 12,
    parameter int unsigned MAX_TERMS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    input  logic              prod_last,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  sum_out,
    output logic [7:0]        sum_terms,
    output logic              sum_sat,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              overrun
);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [7:0]       cnt;
    logic             sat;
    logic             accept;
    logic [SAT_W:0]   add_res;
    logic [7:0]       cnt_next;
    logic             flush;

    always_comb begin
        accept   = prod_valid & prod_ready;
        add_res  = sat_add(SAT_W'(acc), prod_in, ACC_W);
        cnt_next = cnt + 8'd1;
        flush    = prod_last | (cnt_next == 8'(MAX_TERMS));
    end

    if (ACC_W < SAT_W) begin : g_pad
        logic unused_hi;
        assign unused_hi = ^add_res[SAT_W-1:ACC_W];
    end

    // The accumulator registers double as the held sum outputs in HOLD.
    assign sum_out   = acc;
    assign sum_terms = cnt;
    assign sum_sat   = sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            sat        <= 1'b0;
            sum_valid  <= 1'b0;
            prod_ready <= 1'b1;
            overrun    <= 1'b0;
        end else begin
            if (prod_valid && !prod_ready) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc <= ACC_W'(prod_in);
                        cnt <= 8'd1;
                        sat <= 1'b0;
                        if (prod_last) begin
                            state      <= HOLD;
                            sum_valid  <= 1'b1;
                            prod_ready <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= add_res[ACC_W-1:0];
                        sat <= sat | add_res[SAT_W];
                        cnt <= cnt_next;
                        if (flush) begin
                            state      <= HOLD;
                            sum_valid  <= 1'b1;
                            prod_ready <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (sum_ready) begin
                        state      <= IDLE;
                        acc        <= '0;
                        cnt        <= '0;
                        sat        <= 1'b0;
                        sum_valid  <= 1'b0;
                        prod_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    sum_valid  <= 1'b0;
                    prod_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_accum_stage.sv
// Scoreboard bench for mul_accum_stage: a 12-bit and an 8-bit instance share stimulus.
module tb_mul_accum_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  prod_in;
    logic        prod_valid;
    logic        prod_last;
    logic        sum_ready;

    logic        a_prod_ready, a_sum_sat, a_sum_valid, a_overrun;
    logic [11:0] a_sum_out;
    logic [7:0]  a_sum_terms;
    logic        b_prod_ready, b_sum_sat, b_sum_valid, b_overrun;
    logic [7:0]  b_sum_out;
    logic [7:0]  b_sum_terms;

    typedef struct {
        int sum;
        int terms;
        bit sat;
    } exp_t;

    exp_t q12[$];
    exp_t q8[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mul_accum_stage #(.ACC_W(12), .MAX_TERMS(16)) dut (
        .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
        .prod_last(prod_last), .prod_ready(a_prod_ready), .sum_out(a_sum_out),
        .sum_terms(a_sum_terms), .sum_sat(a_sum_sat), .sum_valid(a_sum_valid),
        .sum_ready(sum_ready), .overrun(a_overrun)
    );

    mul_accum_stage #(.ACC_W(8), .MAX_TERMS(16)) dut8 (
        .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
        .prod_last(prod_last), .prod_ready(b_prod_ready), .sum_out(b_sum_out),
        .sum_terms(b_sum_terms), .sum_sat(b_sum_sat), .sum_valid(b_sum_valid),
        .sum_ready(sum_ready), .overrun(b_overrun)
    );

    task automatic push_frame(input int total, input int terms);
        exp_t e;
        e.terms = terms;
        e.sat   = (total > 4095);
        e.sum   = e.sat ? 4095 : total;
        q12.push_back(e);
        e.sat   = (total > 255);
        e.sum   = e.sat ? 255 : total;
        q8.push_back(e);
    endtask

    task automatic send(input logic [7:0] p, input bit last, input bit wait_ready);
        int budget;
        @(negedge clk);
        if (wait_ready) begin
            budget = 20;
            while (!a_prod_ready && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (budget == 0) begin
                checks++;
                errors++;
                $display("FAIL send_wait prod_ready got 0 want 1 within 20 cycles");
            end
        end
        prod_in    = p;
        prod_valid = 1'b1;
        prod_last  = last;
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    task automatic check_sum(input string name);
        exp_t e;
        checks++;
        if (a_sum_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s a_sum_valid got %b want 1", name, a_sum_valid);
        end
        checks++;
        if (b_sum_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s b_sum_valid got %b want 1", name, b_sum_valid);
        end
        checks++;
        if (q12.size() == 0 || q8.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard got empty want entry", name);
        end else begin
            e = q12.pop_front();
            checks++;
            if (a_sum_out !== 12'(e.sum)) begin
                errors++;
                $display("FAIL %s a_sum_out got %0d want %0d", name, a_sum_out, e.sum);
            end
            checks++;
            if (a_sum_terms !== 8'(e.terms)) begin
                errors++;
                $display("FAIL %s a_sum_terms got %0d want %0d", name, a_sum_terms, e.terms);
            end
            checks++;
            if (a_sum_sat !== e.sat) begin
                errors++;
                $display("FAIL %s a_sum_sat got %b want %b", name, a_sum_sat, e.sat);
            end
            e = q8.pop_front();
            checks++;
            if (b_sum_out !== 8'(e.sum)) begin
                errors++;
                $display("FAIL %s b_sum_out got %0d want %0d", name, b_sum_out, e.sum);
            end
            checks++;
            if (b_sum_terms !== 8'(e.terms)) begin
                errors++;
                $display("FAIL %s b_sum_terms got %0d want %0d", name, b_sum_terms, e.terms);
            end
            checks++;
            if (b_sum_sat !== e.sat) begin
                errors++;
                $display("FAIL %s b_sum_sat got %b want %b", name, b_sum_sat, e.sat);
            end
        end
    endtask

    task automatic release_sum(input string name);
        sum_ready = 1'b1;
        @(posedge clk);
        #1;
        sum_ready = 1'b0;
        checks++;
        if (a_sum_valid !== 1'b0 || b_sum_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_release sum_valid got %b/%b want 0/0", name, a_sum_valid, b_sum_valid);
        end
        checks++;
        if (a_prod_ready !== 1'b1 || b_prod_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release prod_ready got %b/%b want 1/1", name, a_prod_ready, b_prod_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a_prod_ready !== 1'b1 || b_prod_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_prod_ready got %b/%b want 1/1", a_prod_ready, b_prod_ready);
        end
        checks++;
        if (a_sum_valid !== 1'b0 || b_sum_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_sum_valid got %b/%b want 0/0", a_sum_valid, b_sum_valid);
        end
        checks++;
        if (a_sum_out !== 12'd0 || a_sum_terms !== 8'd0 || a_sum_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_sum got %0d/%0d/%b want 0/0/0", a_sum_out, a_sum_terms, a_sum_sat);
        end
        checks++;
        if (a_overrun !== 1'b0 || b_overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_overrun got %b/%b want 0/0", a_overrun, b_overrun);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_and_hold();
        push_frame(60, 3);
        send(8'd10, 1'b0, 1'b1);
        send(8'd20, 1'b0, 1'b1);
        send(8'd30, 1'b1, 1'b1);
        check_sum("basic");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (a_sum_valid !== 1'b1 || a_sum_out !== 12'd60 || a_prod_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cycle %0d got v=%b sum=%0d rdy=%b want v=1 sum=60 rdy=0",
                         i, a_sum_valid, a_sum_out, a_prod_ready);
            end
        end
        release_sum("hold");
    endtask

    task automatic test_last_ignored();
        @(negedge clk);
        prod_last = 1'b1;
        @(posedge clk);
        #1;
        prod_last = 1'b0;
        checks++;
        if (a_sum_valid !== 1'b0 || a_prod_ready !== 1'b1) begin
            errors++;
            $display("FAIL last_ignored got v=%b rdy=%b want v=0 rdy=1", a_sum_valid, a_prod_ready);
        end
    endtask

    task automatic test_single();
        push_frame(225, 1);
        send(8'd225, 1'b1, 1'b1);
        check_sum("single");
        release_sum("single");
    endtask

    task automatic test_saturate();
        push_frame(300, 2);
        send(8'd200, 1'b0, 1'b1);
        send(8'd100, 1'b1, 1'b1);
        check_sum("saturate");
        release_sum("saturate");
        push_frame(255 + 255 + 255 + 255 + 255 + 255 + 255 + 255 + 255 + 255 + 255 + 255 + 255 + 255 + 255 + 255, 16);
        for (int i = 0; i < 16; i++) send(8'd255, 1'b0, 1'b1);
        check_sum("saturate_wide");
        release_sum("saturate_wide");
    endtask

    task automatic test_max_terms();
        push_frame(16, 16);
        for (int i = 1; i <= 20; i++) begin
            send(8'd1, 1'b0, 1'b0);
            if (i == 16) begin
                check_sum("max_terms");
                checks++;
                if (a_overrun !== 1'b0) begin
                    errors++;
                    $display("FAIL max_terms_no_overrun got %b want 0", a_overrun);
                end
            end
        end
        checks++;
        if (a_overrun !== 1'b1 || b_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set got %b/%b want 1/1", a_overrun, b_overrun);
        end
        checks++;
        if (a_sum_out !== 12'd16 || a_sum_terms !== 8'd16) begin
            errors++;
            $display("FAIL overrun_discard got %0d/%0d want 16/16", a_sum_out, a_sum_terms);
        end
        release_sum("max_terms");
        checks++;
        if (a_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky got %b want 1", a_overrun);
        end
    endtask

    task automatic test_reset_mid_frame();
        send(8'd3, 1'b0, 1'b1);
        send(8'd4, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (a_sum_valid !== 1'b0 || a_prod_ready !== 1'b1 || a_sum_terms !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset got v=%b rdy=%b terms=%0d want 0/1/0", a_sum_valid, a_prod_ready, a_sum_terms);
        end
        push_frame(5, 1);
        send(8'd5, 1'b1, 1'b1);
        check_sum("after_reset");
        checks++;
        if (a_overrun !== 1'b0 || b_overrun !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_overrun got %b/%b want 0/0", a_overrun, b_overrun);
        end
        release_sum("after_reset");
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [6];
        bit         lasts[6];
        vals  = '{8'd7, 8'd8, 8'd9, 8'd1, 8'd2, 8'd3};
        lasts = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        push_frame(15, 2);
        push_frame(9, 1);
        push_frame(6, 3);
        sum_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(vals[i], lasts[i], 1'b1);
            if (lasts[i]) begin
                check_sum("back_to_back");
                checks++;
                if (a_prod_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_bubble prod_ready got %b want 0", a_prod_ready);
                end
            end
        end
        @(posedge clk);
        #1;
        sum_ready = 1'b0;
        checks++;
        if (a_sum_valid !== 1'b0 || q12.size() != 0 || a_overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got v=%b q=%0d ovr=%b want 0/0/0", a_sum_valid, q12.size(), a_overrun);
        end
    endtask

    initial begin
        rst        = 1'b1;
        prod_in    = '0;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        sum_ready  = 1'b0;
        test_reset();
        test_basic_and_hold();
        test_last_ignored();
        test_single();
        test_saturate();
        test_max_terms();
        test_reset_mid_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
